// File: rtl/mips_muldiv_pkg.sv
// Shared types and sizing helpers for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    function automatic int unsigned div_cnt_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned DIV_CNT_W = div_cnt_w(MULDIV_WIDTH);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/mips_divider_core.sv
// Iterative unsigned restoring divider: one quotient bit per step, MSB first.
module mips_divider_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // quo doubles as the dividend shift register; quotient bits enter at the LSB
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dsr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
            quo <= '0;
            dsr <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dsr <= divisor;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO owner: single-cycle-latched multiply, iterative signed/unsigned divide, MTHI/MTLO.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = div_cnt_w(WIDTH);

    muldiv_state_t      state;
    muldiv_op_t         op_e;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_signed;
    logic               sign_q;
    logic               sign_r;
    logic               nowrite;
    logic [CNT_W-1:0]   count;
    logic               div_signed;
    logic               div_load;
    logic               div_step;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    // Magnitudes are taken unsigned, so -MIN maps back to MIN without overflow.
    always_comb begin
        op_e       = muldiv_op_t'(op);
        div_signed = (op_e == OP_DIV);
        a_abs      = (div_signed && a[WIDTH-1]) ? -a : a;
        b_abs      = (div_signed && b[WIDTH-1]) ? -b : b;
        div_load   = (state == IDLE) && start && (op_e == OP_DIV || op_e == OP_DIVU)
                     && (b != '0);
        div_step   = (state == DIV);
        ext_a      = {{WIDTH{mul_signed & mul_a[WIDTH-1]}}, mul_a};
        ext_b      = {{WIDTH{mul_signed & mul_b[WIDTH-1]}}, mul_b};
        product    = ext_a * ext_b;
    end

    mips_divider_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
            count      <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            nowrite    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        case (op_e)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MULT, OP_MULTU: begin
                                mul_a      <= a;
                                mul_b      <= b;
                                mul_signed <= (op_e == OP_MULT);
                                state      <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (b == '0) begin
                                    nowrite <= 1'b1;
                                    state   <= FIX;
                                end else begin
                                    nowrite <= 1'b0;
                                    sign_q  <= div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    sign_r  <= div_signed & a[WIDTH-1];
                                    count   <= '0;
                                    state   <= DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    {hi, lo} <= product;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                DIV: begin
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (!nowrite) begin
                        lo <= sign_q ? -quotient : quotient;
                        hi <= sign_r ? -remainder : remainder;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
